// File: rtl/csr_intr_unit_if.sv
// Bus between the control FSM / datapath and the machine-mode CSR + interrupt unit.
// master = control side, slave = csr_intr_unit.
interface csr_intr_unit_if;
  logic        int_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        int_taken;
  logic        mret_exec;
  logic [31:0] pc;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;
  logic        intr_req;

  modport master (
    output int_in, csr_we, csr_addr, csr_wd, int_taken, mret_exec, pc,
    input  csr_rd, mtvec, mepc, mie, intr_req
  );

  modport slave (
    input  int_in, csr_we, csr_addr, csr_wd, int_taken, mret_exec, pc,
    output csr_rd, mtvec, mepc, mie, intr_req
  );
endinterface

// File: rtl/csr_intr_unit.sv
// Machine-mode CSRs (mstatus/mtvec/mepc/mcause) and external interrupt capture.
// Optional 64-bit mcycle counter at 0xB00/0xB80 when CSR_MCYCLE_EN is defined.
module csr_intr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
  input  logic          clk,
  input  logic          rst,
  csr_intr_unit_if.slave bus
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic                   pending_q, pending_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic [31:0]            mtvec_q, mtvec_d;
  logic [31:0]            mepc_q, mepc_d;
  logic [31:0]            mcause_q, mcause_d;
  logic                   s, rise;
  logic                   wr_mstatus, wr_mtvec, wr_mepc;

  assign s          = sync_q[SYNC_STAGES-1];
  assign rise       = s & ~s_d_q;
  assign wr_mstatus = bus.csr_we && (bus.csr_addr == A_MSTATUS);
  assign wr_mtvec   = bus.csr_we && (bus.csr_addr == A_MTVEC);
  assign wr_mepc    = bus.csr_we && (bus.csr_addr == A_MEPC);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.int_in};
    s_d_d     = s;
    // A rise coinciding with trap entry must survive the clear.
    pending_d = bus.int_taken ? rise : (pending_q | rise);
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtvec_d   = wr_mtvec ? {bus.csr_wd[31:2], 2'b00} : mtvec_q;
    if (bus.int_taken) begin
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mepc_d   = {bus.pc[31:2], 2'b00};
      mcause_d = MCAUSE_EXT;
    end else begin
      if (bus.mret_exec) begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end else if (wr_mstatus) begin
        mie_d  = bus.csr_wd[3];
        mpie_d = bus.csr_wd[7];
      end
      if (wr_mepc) mepc_d = {bus.csr_wd[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      s_d_q     <= 1'b0;
      pending_q <= 1'b0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      sync_q    <= sync_d;
      s_d_q     <= s_d_d;
      pending_q <= pending_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_q, mcycle_d;

  // Writing one half suppresses the increment, so no carry crosses halves that cycle.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (bus.csr_we && bus.csr_addr == A_MCYCLE)  mcycle_d = {mcycle_q[63:32], bus.csr_wd};
    if (bus.csr_we && bus.csr_addr == A_MCYCLEH) mcycle_d = {bus.csr_wd, mcycle_q[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcycle_q <= '0;
    else     mcycle_q <= mcycle_d;
  end
`endif

  always_comb begin
    bus.csr_rd = '0;
    case (bus.csr_addr)
      A_MSTATUS: bus.csr_rd = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MTVEC:   bus.csr_rd = mtvec_q;
      A_MEPC:    bus.csr_rd = mepc_q;
      A_MCAUSE:  bus.csr_rd = mcause_q;
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:  bus.csr_rd = mcycle_q[31:0];
      A_MCYCLEH: bus.csr_rd = mcycle_q[63:32];
`endif
      default:   bus.csr_rd = '0;
    endcase
  end

  assign bus.mtvec    = mtvec_q;
  assign bus.mepc     = mepc_q;
  assign bus.mie      = mie_q;
  assign bus.intr_req = pending_q & mie_q;

endmodule

// File: tb/tb_csr_intr_unit.sv
// Self-checking bench for csr_intr_unit: directed scenarios plus randomized
// traffic against an event-level reference model.
module tb_csr_intr_unit;
  localparam int          SYNC   = 2;
  localparam logic [31:0] MTV_RST = 32'h0000_1000;
  localparam logic [31:0] MCAUSE  = 32'h8000_000B;

  logic clk = 1'b0;
  logic rst;
  csr_intr_unit_if bus();

  csr_intr_unit #(.MTVEC_RESET(MTV_RST), .SYNC_STAGES(SYNC), .MCAUSE_EXT(MCAUSE)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // reference model state
  bit        m_mie, m_mpie, m_pend;
  bit [31:0] m_mtvec, m_mepc, m_mcause;
  bit [63:0] m_cyc;
  bit        hist [0:SYNC];   // hist[k] = int_in as seen k edges ago

  function automatic bit [31:0] exp_rd(input bit [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_MCYCLE_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_pend = 0;
    m_mtvec = MTV_RST; m_mepc = 0; m_mcause = 0; m_cyc = 0;
    for (int i = 0; i <= SYNC; i++) hist[i] = 0;
  endtask

  task automatic model_edge();
    bit rise;
    bit we_st;
    rise  = hist[SYNC-1] && !hist[SYNC];
    we_st = bus.csr_we && bus.csr_addr == 12'h300;
    if (bus.csr_we && bus.csr_addr == 12'h305) m_mtvec = bus.csr_wd & ~32'h3;
    if (bus.int_taken) begin
      m_pend = rise;
      m_mpie = m_mie; m_mie = 0;
      m_mepc = bus.pc & ~32'h3;
      m_mcause = MCAUSE;
    end else begin
      m_pend = m_pend || rise;
      if (bus.mret_exec) begin m_mie = m_mpie; m_mpie = 1; end
      else if (we_st) begin m_mie = bus.csr_wd[3]; m_mpie = bus.csr_wd[7]; end
      if (bus.csr_we && bus.csr_addr == 12'h341) m_mepc = bus.csr_wd & ~32'h3;
    end
    if (bus.csr_we && bus.csr_addr == 12'hB00)      m_cyc = {m_cyc[63:32], bus.csr_wd};
    else if (bus.csr_we && bus.csr_addr == 12'hB80) m_cyc = {bus.csr_wd, m_cyc[31:0]};
    else m_cyc = m_cyc + 1;
    for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.int_in;
  endtask

  // called at posedge+1; checks mid-cycle, advances one edge, returns at posedge+1
  task automatic step();
    #4;
    chk("intr_req", 32'(bus.intr_req), 32'(m_pend && m_mie));
    chk("mie", 32'(bus.mie), 32'(m_mie));
    chk("mtvec", bus.mtvec, m_mtvec);
    chk("mepc", bus.mepc, m_mepc);
    chk("csr_rd", bus.csr_rd, exp_rd(bus.csr_addr));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mtvec", bus.mtvec, MTV_RST);
    chk("rst_mepc", bus.mepc, 32'd0);
    chk("rst_mie", 32'(bus.mie), 32'd0);
    chk("rst_intr_req", 32'(bus.intr_req), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.csr_we = 0; bus.int_taken = 0; bus.mret_exec = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1; bus.csr_addr = a; bus.csr_wd = d;
    step();
    bus.csr_we = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e);
    bus.csr_addr = a;
    #1;
    chk(tag, bus.csr_rd, e);
  endtask

  logic [11:0] addrs [8] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'h000, 12'h7C0};

  initial begin
    logic [31:0] hi;
    rst = 1'b1;
    bus.int_in = 0; bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wd = 0;
    bus.int_taken = 0; bus.mret_exec = 0; bus.pc = 0;
    @(posedge clk); #1;
    model_reset();
    chk("init_mtvec", bus.mtvec, MTV_RST);
    chk("init_intr_req", 32'(bus.intr_req), 32'd0);
    rst = 1'b0;
    step();

    // mtvec write forces word alignment
    csr_write(12'h305, 32'h0000_0107);
    chk("mtvec_wr", bus.mtvec, 32'h0000_0104);
    rd_chk("mtvec_rd", 12'h305, 32'h0000_0104);

    // MIE=1, rising int_in -> intr_req exactly SYNC+1 edges later
    csr_write(12'h300, 32'h0000_0008);
    bus.int_in = 1;
    step(); step();
    chk("req_early", 32'(bus.intr_req), 32'd0);
    step();
    chk("req_on_time", 32'(bus.intr_req), 32'd1);

    bus.int_taken = 1; bus.pc = 32'h0000_0040;
    step();
    idle();
    chk("trap_mepc", bus.mepc, 32'h0000_0040);
    chk("trap_mie", 32'(bus.mie), 32'd0);
    chk("trap_req", 32'(bus.intr_req), 32'd0);
    rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
    rd_chk("trap_mstatus", 12'h300, 32'h0000_0080);

    // mret with int_in still held high: no second event
    bus.mret_exec = 1;
    step();
    idle();
    rd_chk("mret_mstatus", 12'h300, 32'h0000_0088);
    step(); step(); step(); step();
    chk("held_no_req", 32'(bus.intr_req), 32'd0);

    // pending retained while MIE=0, fires when re-enabled
    csr_write(12'h300, 32'h0);
    bus.int_in = 0; step();
    bus.int_in = 1; step(); step(); step(); step();
    chk("masked_req", 32'(bus.intr_req), 32'd0);
    csr_write(12'h300, 32'h0000_0008);
    chk("unmask_req", 32'(bus.intr_req), 32'd1);

    // int_taken beats mret and a same-cycle mepc write
    bus.int_taken = 1; bus.mret_exec = 1; bus.pc = 32'h0000_0088;
    bus.csr_we = 1; bus.csr_addr = 12'h341; bus.csr_wd = 32'h1234_5678;
    step();
    idle();
    chk("prio_mepc", bus.mepc, 32'h0000_0088);
    rd_chk("prio_mstatus", 12'h300, 32'h0000_0080);

    // mcause is read-only
    csr_write(12'h342, 32'hDEAD_BEEF);
    rd_chk("mcause_ro", 12'h342, 32'h8000_000B);

`ifdef CSR_MCYCLE_EN
    csr_write(12'hB00, 32'hFFFF_FFFF);
    rd_chk("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("cyc_hi_hold", 12'hB80, m_cyc[63:32]);
    hi = bus.csr_rd;
    step();
    rd_chk("cyc_lo_wrap", 12'hB00, 32'd0);
    rd_chk("cyc_hi_inc", 12'hB80, hi + 32'd1);
`else
    hi = 32'd0;
    csr_write(12'hB00, 32'hFFFF_FFFF);
    rd_chk("cyc_absent_lo", 12'hB00, hi);
    rd_chk("cyc_absent_hi", 12'hB80, hi);
`endif

    // reset with a rise in flight
    bus.int_in = 0; step(); step();
    bus.int_in = 1; step(); step();
    pulse_rst();
    chk("post_rst_mtvec", bus.mtvec, MTV_RST);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) bus.int_in = ~bus.int_in;
      bus.csr_we    = ($urandom_range(2) == 0);
      bus.csr_addr  = addrs[$urandom_range(7)];
      bus.csr_wd    = $urandom;
      bus.int_taken = ($urandom_range(11) == 0);
      bus.mret_exec = ($urandom_range(11) == 0);
      bus.pc        = $urandom;
      if ($urandom_range(249) == 0) pulse_rst();
      else step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
